// File: rtl/u_alu_divider_pkg.sv
// Shared types and helpers for the iterative RV32M divide/remainder unit.
// Holds the operation encodings, FSM state codes and operand width.
package u_alu_divider_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ITER_CNT_W = 6;

  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam word_t WORD_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_ITER = 2'd1,
    DIV_ST_FIN  = 2'd2
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

  function automatic word_t neg_if(input logic neg, input word_t v);
    return neg ? word_t'(-v) : v;
  endfunction

endpackage

// File: rtl/u_alu_divider_if.sv
// Request/response bundle between the IEX stage (master) and the divider (slave).
interface u_alu_divider_if;
  import u_alu_divider_pkg::*;

  logic        start;
  logic        flush;
  logic [1:0]  div_op;
  word_t       div_data_in_1;
  word_t       div_data_in_2;
  logic        busy;
  logic        done;
  word_t       div_data_out;

  modport master (
    output start, flush, div_op, div_data_in_1, div_data_in_2,
    input  busy, done, div_data_out
  );

  modport slave (
    input  start, flush, div_op, div_data_in_1, div_data_in_2,
    output busy, done, div_data_out
  );

endinterface

// File: rtl/u_div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor,
// keep the difference and set the new quotient bit when it does not borrow.
module u_div_step
  import u_alu_divider_pkg::*;
(
  input  word_t rem_i,
  input  word_t quo_i,
  input  word_t divisor_i,
  output word_t rem_o,
  output word_t quo_o
);

  logic [DATA_WIDTH:0] rem_sh;
  logic                take_trial;
  word_t               trial;

  assign rem_sh     = {rem_i, quo_i[DATA_WIDTH-1]};
  // The true difference always fits in a word when it is kept, so wrapping is harmless.
  assign take_trial = (rem_sh >= {1'b0, divisor_i});
  assign trial      = rem_sh[DATA_WIDTH-1:0] - divisor_i;

  assign rem_o = take_trial ? trial : rem_sh[DATA_WIDTH-1:0];
  assign quo_o = {quo_i[DATA_WIDTH-2:0], take_trial};

endmodule

// File: rtl/u_alu_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: FSM, iteration counter, operand
// registers and sign fix-up around a combinational restoring step.
module u_alu_divider
  import u_alu_divider_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  u_alu_divider_if.slave div_if
);

  div_state_e              state_q, state_d;
  logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
  word_t                   rem_q, rem_d;
  word_t                   quo_q, quo_d;
  word_t                   dvs_q, dvs_d;
  word_t                   out_q, out_d;
  div_op_e                 op_q, op_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    fast_q, fast_d;
  logic                    done_q, done_d;

  word_t   step_rem, step_quo;
  div_op_e op_in;
  logic    signed_in, div_by_zero, overflow;
  word_t   abs_a, abs_b;

  assign op_in       = div_op_e'(div_if.div_op);
  assign signed_in   = op_is_signed(op_in);
  assign abs_a       = neg_if(signed_in & div_if.div_data_in_1[DATA_WIDTH-1], div_if.div_data_in_1);
  assign abs_b       = neg_if(signed_in & div_if.div_data_in_2[DATA_WIDTH-1], div_if.div_data_in_2);
  assign div_by_zero = (div_if.div_data_in_2 == '0);
  assign overflow    = signed_in && (div_if.div_data_in_1 == WORD_MIN) && (div_if.div_data_in_2 == '1);

  u_div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    out_d     = out_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    fast_d    = fast_q;
    done_d    = 1'b0;

    if (div_if.flush) begin
      state_d = DIV_ST_IDLE;
      fast_d  = 1'b0;
    end else begin
      unique case (state_q)
        DIV_ST_IDLE: begin
          if (div_if.start) begin
            op_d  = op_in;
            dvs_d = abs_b;
            cnt_d = '0;
            // Special cases load final results directly; no sign fix-up applies.
            if (div_by_zero || overflow) begin
              quo_d     = div_by_zero ? '1 : WORD_MIN;
              rem_d     = div_by_zero ? div_if.div_data_in_1 : '0;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              fast_d    = 1'b1;
              state_d   = DIV_ST_FIN;
            end else begin
              quo_d     = abs_a;
              rem_d     = '0;
              neg_quo_d = signed_in & (div_if.div_data_in_1[DATA_WIDTH-1] ^ div_if.div_data_in_2[DATA_WIDTH-1]);
              neg_rem_d = signed_in & div_if.div_data_in_1[DATA_WIDTH-1];
              state_d   = DIV_ST_ITER;
            end
          end
        end
        DIV_ST_ITER: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == ITER_CNT_W'(DATA_WIDTH - 1)) state_d = DIV_ST_FIN;
        end
        DIV_ST_FIN: begin
          // The fast path spends one extra FIN cycle so its done lands two edges after accept.
          if (fast_q) begin
            fast_d = 1'b0;
          end else begin
            out_d   = op_is_rem(op_q) ? neg_if(neg_rem_q, rem_q) : neg_if(neg_quo_q, quo_q);
            done_d  = 1'b1;
            state_d = DIV_ST_IDLE;
          end
        end
        default: state_d = DIV_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      out_q     <= '0;
      op_q      <= DIV_OP_DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fast_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      out_q     <= out_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      fast_q    <= fast_d;
      done_q    <= done_d;
    end
  end

  assign div_if.busy         = (state_q != DIV_ST_IDLE);
  assign div_if.done         = done_q;
  assign div_if.div_data_out = out_q;

endmodule

// File: tb/tb_u_alu_divider.sv
// Self-checking bench for u_alu_divider: a reference model fills a scoreboard
// queue at request time; a negedge monitor pops and compares on every done.
module tb_u_alu_divider;
  import u_alu_divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  u_alu_divider_if div_if ();

  u_alu_divider dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (div_if.slave)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  word_t sb_q[$];
  word_t last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic word_t model(input logic [1:0] op, input word_t a, input word_t b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (!op[0]) begin
      if (b == 0)                          return op[1] ? a : 32'hFFFF_FFFF;
      if (a == 32'h8000_0000 && b == '1)   return op[1] ? 32'h0 : 32'h8000_0000;
      return op[1] ? word_t'(sa % sb) : word_t'(sa / sb);
    end
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] op, input word_t a, input word_t b);
    if (b == 0) return 2;
    if (!op[0] && a == 32'h8000_0000 && b == '1) return 2;
    return 33;
  endfunction

  always @(negedge clk) begin
    if (!rst && div_if.done) begin
      if (sb_q.size() == 0) check("unexp_done", 32'(div_if.done), 32'h0);
      else                  check("data", div_if.div_data_out, sb_q.pop_front());
    end
  end

  // Issue one request; optionally pulse start with junk operands while busy.
  task automatic do_op(input logic [1:0] op, input word_t a, input word_t b, input bit noise);
    int lat;
    word_t exp;
    exp = model(op, a, b);
    lat = 99;
    div_if.start         = 1'b1;
    div_if.div_op        = op;
    div_if.div_data_in_1 = a;
    div_if.div_data_in_2 = b;
    sb_q.push_back(exp);
    @(posedge clk);
    #1 div_if.start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) check("busy_run", 32'(div_if.busy), 32'h1);
      if (div_if.done) begin
        lat = n;
        check("busy_at_done", 32'(div_if.busy), 32'h0);
        break;
      end
      if (noise && (n % 7 == 3)) begin
        div_if.start         = 1'b1;
        div_if.div_op        = ~op;
        div_if.div_data_in_1 = $urandom;
        div_if.div_data_in_2 = $urandom_range(1, 9);
      end else begin
        div_if.start = 1'b0;
      end
    end
    div_if.start = 1'b0;
    check("latency", 32'(lat), 32'(model_lat(op, a, b)));
    if (lat == 99 && sb_q.size() != 0) void'(sb_q.pop_front());
    last_res = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] op;
    word_t a, b;
    div_if.start         = 1'b0;
    div_if.flush         = 1'b0;
    div_if.div_op        = 2'b00;
    div_if.div_data_in_1 = '0;
    div_if.div_data_in_2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(div_if.busy), 32'h0);
    check("rst_done", 32'(div_if.done), 32'h0);
    check("rst_out", div_if.div_data_out, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_op(DIV_OP_DIVU, 32'd100, 32'd7, 1'b0);
    do_op(DIV_OP_REMU, 32'd100, 32'd7, 1'b0);
    do_op(DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(DIV_OP_DIV,  32'd5, 32'd0, 1'b0);
    do_op(DIV_OP_REM,  32'd5, 32'd0, 1'b0);
    do_op(DIV_OP_DIVU, 32'd5, 32'd0, 1'b0);
    do_op(DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(DIV_OP_REM,  32'd1234567, 32'hFFFF_FFF6, 1'b1);
    do_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b1);

    // Flush after ten iteration steps: no done, output held.
    div_if.start = 1'b1; div_if.div_op = DIV_OP_DIVU;
    div_if.div_data_in_1 = 32'd1000; div_if.div_data_in_2 = 32'd3;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    div_if.flush = 1'b1;
    @(posedge clk);
    #1 div_if.flush = 1'b0;
    check("flush_busy", 32'(div_if.busy), 32'h0);
    check("flush_done", 32'(div_if.done), 32'h0);
    check("flush_hold", div_if.div_data_out, last_res);
    repeat (40) @(negedge clk);
    do_op(DIV_OP_DIVU, 32'd9, 32'd3, 1'b0);

    // Flush and start together: request dropped.
    div_if.start = 1'b1; div_if.flush = 1'b1; div_if.div_op = DIV_OP_DIV;
    div_if.div_data_in_1 = 32'd77; div_if.div_data_in_2 = 32'd7;
    @(posedge clk);
    #1 begin div_if.start = 1'b0; div_if.flush = 1'b0; end
    check("flush_start_busy", 32'(div_if.busy), 32'h0);
    repeat (40) @(negedge clk);

    // Async reset in the middle of iterating.
    div_if.start = 1'b1; div_if.div_op = DIV_OP_REMU;
    div_if.div_data_in_1 = 32'd555; div_if.div_data_in_2 = 32'd10;
    @(posedge clk);
    #1 div_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(div_if.busy), 32'h0);
    check("arst_done", 32'(div_if.done), 32'h0);
    check("arst_out", div_if.div_data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = (i % 5 == 0) ? 32'h8000_0000 : word_t'($urandom);
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = '1;
        2:       b = word_t'($urandom_range(1, 15));
        default: b = word_t'($urandom);
      endcase
      do_op(op, a, b, (i % 4) == 1);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
